biriscv_fetch_ctrl: RTL and testbench
=====================================

// Module: biriscv_fetch_ctrl
// PURPOSE
//  Front-end fetch stage feeding the decode FIFO. Generates the fetch PC, issues one 64-bit
//  I-cache read at a time, and presents {instr pair, pc, pred_branch, faults} to decode with
//  a valid/accept handshake. Handles branch redirects, discards in-flight stale responses,
//  and holds one response in a skid register while decode stalls.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC fetched first after reset
// PORTS
//  clk_i                 in   1   clock
//  rst_i                 in   1   reset, asynchronous, active-high
//  branch_request_i      in   1   redirect (branch/exception/flush), single-cycle pulse
//  branch_pc_i           in   32  redirect target
//  next_pc_f_i           in   32  predictor next PC for current fetch PC
//  next_taken_f_i        in   2   predictor taken per slot ([0]=slot0, [1]=slot1)
//  icache_accept_i       in   1   I-cache accepts request this cycle
//  icache_valid_i        in   1   I-cache response valid (single-cycle)
//  icache_inst_i         in   64  response data {slot1, slot0}
//  icache_error_i        in   1   fetch bus error
//  icache_page_fault_i   in   1   fetch page fault
//  icache_rd_o           out  1   request strobe
//  icache_pc_o           out  32  request address, {pc_q[31:3],3'b000}
//  pc_f_o                out  32  current fetch PC to predictor
//  fetch_valid_o         out  1   bundle valid to decode
//  fetch_instr_o         out  64  bundle data
//  fetch_pc_o            out  32  bundle PC (full PC of request)
//  fetch_pred_branch_o   out  2   next_taken_f_i captured at request issue
//  fetch_fault_fetch_o   out  1   bundle carries bus error
//  fetch_fault_page_o    out  1   bundle carries page fault
//  fetch_accept_i        in   1   decode accepts bundle
// BEHAVIOUR
//  Reset: pc_q=RESET_PC; state=S_REQ; skid empty; all outputs 0 except icache_pc_o/pc_f_o.
//  FSM: S_REQ, S_WAIT, S_DROP, S_HALT.
//   S_REQ: icache_rd_o=1 iff skid empty or (fetch_valid_o & fetch_accept_i). On issue
//    (rd & accept): latch req_pc=pc_q, pred=next_taken_f_i; pc_q<=next_pc_f_i if any taken
//    bit set, else {pc_q[31:3],3'b000}+8; -> S_WAIT.
//   S_WAIT: on icache_valid_i load skid {inst,req_pc,pred,error,page_fault}, valid=1;
//    -> S_HALT if error|page_fault, else -> S_REQ (new request earliest next cycle).
//   S_DROP: entered on redirect while response outstanding; response discarded (no skid
//    write); -> S_REQ.
//   S_HALT: no requests until redirect (trap). Faulting bundle still delivered.
//  Redirect (branch_request_i, highest priority): pc_q<=branch_pc_i; skid cleared;
//   fetch_valid_o=0 next cycle; state -> S_DROP if in S_WAIT without icache_valid_i in same
//   cycle, else -> S_REQ. Request in S_REQ is not issued in redirect cycle. Redirect with
//   same-cycle icache_valid_i: response discarded.
//  Faults: fetch_instr_o forced 64'b0 when either fault bit set.
//  Output: fetch_valid_o=skid valid; skid clears on accept unless reloaded same cycle.
//   Max one bundle per 2 cycles with 1-cycle I-cache; no combinational icache->decode path.
//  Arithmetic: PC increment 32-bit modulo; 0xFFFF_FFF8+8 wraps to 0.
//  Stall: skid full & no accept -> no request; data/pc/pred held stable while valid&!accept.
// TESTING
//  1 Reset, cache always accepts, resp 1 cycle later -> icache_pc_o 0x80000000,0x80000008,
//    ...; bundles in order, pred=2'b00.
//  2 fetch_accept_i=0 for 5 cycles -> one bundle held stable, icache_rd_o=0, no loss.
//  3 Redirect to 0x80000100 while S_WAIT -> stale response dropped; next request 0x80000100.
//  4 Predictor next_taken=2'b01, next_pc=0x80000040 at 0x80000010 -> next req 0x80000040,
//    bundle pred=2'b01, fetch_pc_o=0x80000010.
//  5 page_fault on response -> bundle instr=0, fault_page=1; no further requests until
//    redirect; redirect resumes fetch.
//  6 Async rst_i pulse mid S_WAIT -> all outputs 0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/biriscv_fetch_ctrl.sv
// Fetch stage: drives the fetch PC, keeps one I-cache read in flight, and hands each
// response to decode through a single skid register. Redirects drop stale responses.
module biriscv_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [31:0] pc_f_o,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o,
  input  logic        fetch_accept_i
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [1:0]  req_pred_q;

  logic        skid_valid_q;
  logic [63:0] skid_inst_q;
  logic [31:0] skid_pc_q;
  logic [1:0]  skid_pred_q;
  logic        skid_err_q;
  logic        skid_pf_q;

  logic [31:0] pc_aligned;
  logic        issue;
  logic        resp_load;
  logic        resp_fault;

  assign pc_aligned = {pc_q[31:3], 3'b000};

  // A new read goes out only when the skid will be free to take its response.
  assign icache_rd_o = !rst_i && !branch_request_i && (state_q == S_REQ) &&
                       (!skid_valid_q || fetch_accept_i);
  assign issue       = icache_rd_o && icache_accept_i;
  assign resp_load   = (state_q == S_WAIT) && icache_valid_i && !branch_request_i;
  assign resp_fault  = icache_error_i || icache_page_fault_i;

  assign icache_pc_o = pc_aligned;
  assign pc_f_o      = pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'b0;
      req_pred_q <= 2'b00;
    end else if (branch_request_i) begin
      pc_q <= branch_pc_i;
      // A response still owed by the cache must be swallowed before fetching again.
      if (((state_q == S_WAIT) || (state_q == S_DROP)) && !icache_valid_i)
        state_q <= S_DROP;
      else
        state_q <= S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (issue) begin
            req_pc_q   <= pc_q;
            req_pred_q <= next_taken_f_i;
            pc_q       <= (|next_taken_f_i) ? next_pc_f_i : pc_aligned + 32'd8;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (icache_valid_i)
            state_q <= resp_fault ? S_HALT : S_REQ;
        end
        S_DROP: begin
          if (icache_valid_i)
            state_q <= S_REQ;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_valid_q <= 1'b0;
      skid_inst_q  <= 64'b0;
      skid_pc_q    <= 32'b0;
      skid_pred_q  <= 2'b00;
      skid_err_q   <= 1'b0;
      skid_pf_q    <= 1'b0;
    end else if (branch_request_i) begin
      skid_valid_q <= 1'b0;
    end else if (resp_load) begin
      skid_valid_q <= 1'b1;
      skid_inst_q  <= resp_fault ? 64'b0 : icache_inst_i;
      skid_pc_q    <= req_pc_q;
      skid_pred_q  <= req_pred_q;
      skid_err_q   <= icache_error_i;
      skid_pf_q    <= icache_page_fault_i;
    end else if (fetch_accept_i) begin
      skid_valid_q <= 1'b0;
    end
  end

  assign fetch_valid_o       = skid_valid_q;
  assign fetch_instr_o       = skid_inst_q;
  assign fetch_pc_o          = skid_pc_q;
  assign fetch_pred_branch_o = skid_pred_q;
  assign fetch_fault_fetch_o = skid_err_q;
  assign fetch_fault_page_o  = skid_pf_q;

endmodule

// File: tb/tb_biriscv_fetch_ctrl.sv
// Bench for biriscv_fetch_ctrl: scripted per-cycle vectors, an async reset check, then a
// randomized cache/decode stream checked against a scoreboard of issued requests.
module tb_biriscv_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [63:0] A1 = 64'h0000_1111_0000_0001;
  localparam logic [63:0] A2 = 64'h0000_2222_0000_0002;
  localparam logic [63:0] A3 = 64'h0000_3333_0000_0003;
  localparam logic [63:0] DD = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] B1 = 64'hB1B1_B1B1_0000_00B1;
  localparam logic [63:0] B2 = 64'hB2B2_B2B2_0000_00B2;
  localparam logic [63:0] C1 = 64'hC1C1_C1C1_0000_00C1;
  localparam logic [63:0] C2 = 64'hC2C2_C2C2_0000_00C2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic [31:0] next_pc_f_i;
  logic [1:0]  next_taken_f_i;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic [63:0] icache_inst_i;
  logic        icache_error_i;
  logic        icache_page_fault_i;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic [31:0] pc_f_o;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_pred_branch_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;
  logic        fetch_accept_i;

  always #5 clk_i = ~clk_i;

  biriscv_fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
    .next_pc_f_i(next_pc_f_i), .next_taken_f_i(next_taken_f_i),
    .icache_accept_i(icache_accept_i), .icache_valid_i(icache_valid_i),
    .icache_inst_i(icache_inst_i), .icache_error_i(icache_error_i),
    .icache_page_fault_i(icache_page_fault_i),
    .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o), .pc_f_o(pc_f_o),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
    .fetch_pc_o(fetch_pc_o), .fetch_pred_branch_o(fetch_pred_branch_o),
    .fetch_fault_fetch_o(fetch_fault_fetch_o), .fetch_fault_page_o(fetch_fault_page_o),
    .fetch_accept_i(fetch_accept_i)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic br; logic [31:0] bpc; logic [31:0] npc; logic [1:0] ntk;
    logic iacc; logic ival; logic [63:0] inst; logic err; logic pf; logic facc;
    logic e_rd; logic [31:0] e_pcf; logic e_fv; logic [31:0] e_fpc;
    logic [63:0] e_instr; logic [1:0] e_pred; logic e_ff; logic e_fp;
  } vec_t;
  vec_t vecs[$];

  typedef struct { logic [63:0] inst; logic [31:0] pc; logic [1:0] pred; } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [31:0] model_pc;
  logic [63:0] resp_inst;
  int          lat_cnt;
  logic        prev_stall;
  logic [97:0] prev_dat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic br, input logic [31:0] bpc, input logic [31:0] npc,
                              input logic [1:0] ntk, input logic iacc, input logic ival,
                              input logic [63:0] inst, input logic err, input logic pf,
                              input logic facc, input logic e_rd, input logic [31:0] e_pcf,
                              input logic e_fv, input logic [31:0] e_fpc,
                              input logic [63:0] e_instr, input logic [1:0] e_pred,
                              input logic e_ff, input logic e_fp);
    vec_t v;
    v.br = br; v.bpc = bpc; v.npc = npc; v.ntk = ntk; v.iacc = iacc; v.ival = ival;
    v.inst = inst; v.err = err; v.pf = pf; v.facc = facc;
    v.e_rd = e_rd; v.e_pcf = e_pcf; v.e_fv = e_fv; v.e_fpc = e_fpc;
    v.e_instr = e_instr; v.e_pred = e_pred; v.e_ff = e_ff; v.e_fp = e_fp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    branch_request_i = v.br; branch_pc_i = v.bpc; next_pc_f_i = v.npc;
    next_taken_f_i = v.ntk; icache_accept_i = v.iacc; icache_valid_i = v.ival;
    icache_inst_i = v.inst; icache_error_i = v.err; icache_page_fault_i = v.pf;
    fetch_accept_i = v.facc;
  endtask

  task automatic set_idle();
    branch_request_i = 0; branch_pc_i = 0; next_pc_f_i = 0; next_taken_f_i = 0;
    icache_accept_i = 0; icache_valid_i = 0; icache_inst_i = 0; icache_error_i = 0;
    icache_page_fault_i = 0; fetch_accept_i = 0;
  endtask

  task automatic check_row(input int idx, input vec_t v);
    logic [65:0] act_c, exp_c;
    logic [99:0] act_d, exp_d;
    act_c = {icache_rd_o, icache_pc_o, pc_f_o, fetch_valid_o};
    exp_c = {v.e_rd, v.e_pcf[31:3], 3'b000, v.e_pcf, v.e_fv};
    act_d = v.e_fv ? {fetch_pc_o, fetch_instr_o, fetch_pred_branch_o,
                      fetch_fault_fetch_o, fetch_fault_page_o} : 100'b0;
    exp_d = v.e_fv ? {v.e_fpc, v.e_instr, v.e_pred, v.e_ff, v.e_fp} : 100'b0;
    check($sformatf("vec%0d_ctl", idx), 128'(act_c), 128'(exp_c));
    check($sformatf("vec%0d_dat", idx), 128'(act_d), 128'(exp_d));
  endtask

  initial begin
    set_idle();
    rst_i = 1'b1;
    #1;
    check("reset_state",
          {icache_rd_o, icache_pc_o, pc_f_o, fetch_valid_o, fetch_pc_o, fetch_instr_o,
           fetch_pred_branch_o, fetch_fault_fetch_o, fetch_fault_page_o},
          {1'b0, RESET_PC, RESET_PC, 1'b0, 32'b0, 64'b0, 2'b00, 1'b0, 1'b0});
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    //   br bpc           npc           ntk   ia iv inst er pf fa | rd pcf          fv fpc           instr pred  ff fp
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   1, 32'h80000000, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 1, A1, 0, 0, 1,   0, 32'h80000008, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   1, 32'h80000008, 1, 32'h80000000, A1, 2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 1, A2, 0, 0, 1,   0, 32'h80000010, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            32'h80000040, 2'b01, 1, 0, 0,  0, 0, 1,   1, 32'h80000010, 1, 32'h80000008, A2, 2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 1, A3, 0, 0, 1,   0, 32'h80000040, 0, 0,            0,  2'b00, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0,          0,            2'b00, 1, 0, 0,  0, 0, 0,   0, 32'h80000040, 1, 32'h80000010, A3, 2'b01, 0, 0);
    add(0, 0,            0,            2'b00, 0, 0, 0,  0, 0, 1,   1, 32'h80000040, 1, 32'h80000010, A3, 2'b01, 0, 0);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   1, 32'h80000040, 0, 0,            0,  2'b00, 0, 0);
    add(1, 32'h80000100, 0,            2'b00, 0, 0, 0,  0, 0, 1,   0, 32'h80000048, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 1, DD, 0, 0, 1,   0, 32'h80000100, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   1, 32'h80000100, 0, 0,            0,  2'b00, 0, 0);
    add(1, 32'h80000204, 0,            2'b00, 0, 1, B1, 0, 0, 1,   0, 32'h80000108, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   1, 32'h80000204, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 1, B2, 0, 1, 1,   0, 32'h80000208, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 0,   0, 32'h80000208, 1, 32'h80000204, 0,  2'b00, 0, 1);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   0, 32'h80000208, 1, 32'h80000204, 0,  2'b00, 0, 1);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   0, 32'h80000208, 0, 0,            0,  2'b00, 0, 0);
    add(1, 32'h80000300, 0,            2'b00, 1, 0, 0,  0, 0, 1,   0, 32'h80000208, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 1,   1, 32'h80000300, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 1, C1, 1, 0, 0,   0, 32'h80000308, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 0, 0,  0, 0, 0,   0, 32'h80000308, 1, 32'h80000300, 0,  2'b00, 1, 0);
    add(1, 32'hFFFFFFF8, 0,            2'b00, 0, 0, 0,  0, 0, 0,   0, 32'h80000308, 1, 32'h80000300, 0,  2'b00, 1, 0);
    add(0, 0,            0,            2'b00, 1, 0, 0,  0, 0, 0,   1, 32'hFFFFFFF8, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 1, C2, 0, 0, 0,   0, 32'h00000000, 0, 0,            0,  2'b00, 0, 0);
    add(0, 0,            0,            2'b00, 0, 0, 0,  0, 0, 1,   1, 32'h00000000, 1, 32'hFFFFFFF8, C2, 2'b00, 0, 0);

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      drive(vecs[i]);
      @(negedge clk_i);
      check_row(i, vecs[i]);
    end

    // Async reset while a read is outstanding.
    @(posedge clk_i); #1;
    set_idle();
    icache_accept_i = 1; fetch_accept_i = 1;
    @(negedge clk_i);
    check("pre_rst_issue", 128'(icache_rd_o), 128'(1'b1));
    @(posedge clk_i); #1;
    icache_accept_i = 0;
    #2 rst_i = 1'b1;
    #1;
    check("async_rst",
          {icache_rd_o, icache_pc_o, pc_f_o, fetch_valid_o, fetch_pc_o, fetch_instr_o,
           fetch_pred_branch_o, fetch_fault_fetch_o, fetch_fault_page_o},
          {1'b0, RESET_PC, RESET_PC, 1'b0, 32'b0, 64'b0, 2'b00, 1'b0, 1'b0});
    @(negedge clk_i);
    rst_i = 1'b0;

    // Randomized stream against a scoreboard.
    model_pc = RESET_PC; lat_cnt = 0; resp_inst = 0; prev_stall = 0; prev_dat = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk_i); #1;
      icache_valid_i = 0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          icache_valid_i = 1;
          icache_inst_i  = resp_inst;
        end
      end
      if (cyc < 560) begin
        icache_accept_i = ($urandom_range(3) != 0);
        fetch_accept_i  = ($urandom_range(9) < 7);
      end else begin
        icache_accept_i = 0;
        fetch_accept_i  = 1;
      end
      next_taken_f_i = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      next_pc_f_i    = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
      @(negedge clk_i);

      if (prev_stall)
        check("stall_hold", {fetch_valid_o, fetch_pc_o, fetch_instr_o, fetch_pred_branch_o},
              {1'b1, prev_dat});
      if (fetch_valid_o && !fetch_accept_i)
        check("stall_no_rd", 128'(icache_rd_o), 128'(1'b0));

      if (icache_rd_o && icache_accept_i) begin
        check("req_pc", 128'(icache_pc_o), 128'({model_pc[31:3], 3'b000}));
        e.pc   = model_pc;
        e.pred = next_taken_f_i;
        e.inst = {~{model_pc[31:3], 3'b000}, model_pc[31:3], 3'b000};
        sb.push_back(e);
        resp_inst = e.inst;
        lat_cnt   = $urandom_range(1, 3);
        model_pc  = (|next_taken_f_i) ? next_pc_f_i : {model_pc[31:3], 3'b000} + 32'd8;
      end

      if (fetch_valid_o && fetch_accept_i) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow got bundle pc %h want none", fetch_pc_o);
        end else begin
          e = sb.pop_front();
          check("bundle",
                {fetch_pc_o, fetch_instr_o, fetch_pred_branch_o, fetch_fault_fetch_o, fetch_fault_page_o},
                {e.pc, e.inst, e.pred, 2'b00});
        end
      end

      prev_stall = fetch_valid_o && !fetch_accept_i;
      prev_dat   = {fetch_pc_o, fetch_instr_o, fetch_pred_branch_o};
    end
    check("sb_drained", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
